mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Upstream stage that drives the tb_mem_inputs-style port set of the byte-addressed
//  test memory (async read, sync write on the same clock).
//  Accepts one 8/16-bit read or write request at a time over a valid/ready handshake.
//  Sequences the memory strobes, waits a programmable number of cycles before sampling
//  read data, and returns a held response.
//  Sits between the CPU load/store logic and the test memory in simulation benches.
// PARAMETERS
//  ADDR_WIDTH   16  width of all address ports
//  WAIT_STATES  1   extra ACCESS cycles before read data is sampled (0..15)
// PORTS
//  clk             in   1           single clock; also drives the memory's write_clk
//  reset           in   1           synchronous, active-high
//  req_valid       in   1           request present
//  req_ready       out  1           controller can accept (IDLE and reset low)
//  req_we          in   1           1 = write, 0 = read
//  req_sz          in   1           0 = 8-bit, 1 = 16-bit (cpu_data_acc_sz encoding)
//  req_addr        in   ADDR_WIDTH  byte address
//  req_wdata       in   16          write data; 8-bit writes use [7:0]
//  resp_valid      out  1           response held until resp_ready
//  resp_ready      in   1           consumer takes response
//  resp_rdata      out  16          read data; 8-bit reads zero-extended; 0 for writes
//  resp_err        out  1           misaligned-access flag (see CONFIGURATION)
//  mem_read_addr   out  ADDR_WIDTH  to memory read_addr_in
//  mem_read_sz     out  1           to memory read_data_acc_sz
//  mem_write_addr  out  ADDR_WIDTH  to memory write_addr_in
//  mem_write_data  out  16          to memory write_data_in
//  mem_write_sz    out  1           to memory write_data_acc_sz
//  mem_write_we    out  1           to memory write_data_we
//  mem_read_data   in   16          from memory read_data_out
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE; all mem_* outputs, resp_* outputs and
//    wait counter = 0; req_ready=0 while reset is high.
//  - States: IDLE -> ACCESS -> RESP -> IDLE. All outputs registered except req_ready
//    (= state==IDLE && !reset).
//  - IDLE: on req_valid && req_ready at posedge, latch the request; load mem_* outputs
//    (write: mem_write_we=1; read: mem_read_addr/sz); wait counter = WAIT_STATES;
//    go to ACCESS.
//  - ACCESS, write: mem_write_we=1 for exactly this one cycle, so the memory commits
//    at the closing edge. At that edge mem_write_we<=0, resp_rdata<=0, go to RESP.
//  - ACCESS, read: address/size held stable. If counter!=0, decrement. If counter==0,
//    sample mem_read_data into resp_rdata (sz 8: {8'h00, data[7:0]}) and go to RESP.
//  - RESP: resp_valid=1 and resp_rdata/resp_err held. On resp_ready, resp_valid<=0 and
//    go to IDLE. Without resp_ready, stay in RESP indefinitely.
//  - Latency, accept edge to first resp_valid cycle: write = 2 cycles,
//    read = 2+WAIT_STATES cycles. Peak throughput: one request per 3+ cycles; no
//    same-cycle accept in RESP.
//  - req_* inputs are ignored outside IDLE; the latched copy is used throughout.
//  - Addresses pass through unmodified; 16-bit access at max address is the memory's
//    concern. The controller never increments addresses.
//  - Reset asserted in ACCESS/RESP: next edge returns to IDLE; mem_write_we cleared at
//    that edge. The in-flight request is dropped with no response. A write whose
//    ACCESS edge coincides with reset is still committed by the memory (we was already
//    high).
//  - resp_ready high outside RESP: ignored.
// CONFIGURATION
//  MEM_ACC_ALIGN_CHECK_EN defined:
//    - A 16-bit request with addr[0]=1 is accepted but skips memory. No mem_write_we,
//      mem_* outputs unchanged.
//    - Next state is RESP directly with resp_err=1, resp_rdata=0 (latency 1).
//    - resp_err=0 on all other responses.
//  MEM_ACC_ALIGN_CHECK_EN undefined: resp_err tied 0; odd 16-bit accesses performed
//    normally.
// TESTING
//  1. Write 16'h1234 sz16 @0x0040, then read sz16 @0x0040, WAIT_STATES=1 ->
//     write resp 2 cycles after accept; read resp 3 cycles after accept,
//     resp_rdata=16'h1234.
//  2. Write 8'hAB sz8 @0x0041, then read sz8 @0x0041 -> resp_rdata=16'h00AB;
//     mem_write_we high exactly 1 cycle.
//  3. Read with resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable,
//     req_ready=0 throughout; accept next request 1 cycle after resp_ready.
//  4. Assert reset 1 cycle into a WAIT_STATES=3 read -> no resp_valid; IDLE and
//     req_ready=1 one cycle after reset drops.
//  5. MEM_ACC_ALIGN_CHECK_EN: write sz16 @0x0013 -> resp_err=1 next cycle,
//     mem_write_we never high, memory @0x0013 unchanged; without macro -> write occurs,
//     resp_err=0.
//  6. WAIT_STATES=0 read sz16 @0x0000 after memory preload -> resp_valid 2 cycles after
//     accept with preloaded word.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Purpose: sequences one 8/16-bit read or write into an async-read/sync-write test memory.
// Latency: write 2 cycles, read 2+WAIT_STATES cycles, misaligned 1 cycle (MEM_ACC_ALIGN_CHECK_EN).
// Backpressure: req_ready only in IDLE; the response is held in RESP until resp_ready.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_sz,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [15:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic                  mem_read_sz,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [15:0]           mem_write_data,
    output logic                  mem_write_sz,
    output logic                  mem_write_we,
    input  logic [15:0]           mem_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t     state;
    logic       lat_we;
    logic       lat_sz;
    logic [3:0] wait_cnt;
    logic       misaligned;

`ifdef MEM_ACC_ALIGN_CHECK_EN
    assign misaligned = req_sz && req_addr[0];
`else
    assign misaligned = 1'b0;
`endif

    assign req_ready = (state == ST_IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            lat_we         <= 1'b0;
            lat_sz         <= 1'b0;
            wait_cnt       <= '0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_read_addr  <= '0;
            mem_read_sz    <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            mem_write_sz   <= 1'b0;
            mem_write_we   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we   <= req_we;
                        lat_sz   <= req_sz;
                        wait_cnt <= WAIT_INIT;
                        if (misaligned) begin
                            // Odd 16-bit access never touches the memory.
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            resp_err <= 1'b0;
                            if (req_we) begin
                                mem_write_addr <= req_addr;
                                mem_write_data <= req_wdata;
                                mem_write_sz   <= req_sz;
                                mem_write_we   <= 1'b1;
                            end else begin
                                mem_read_addr <= req_addr;
                                mem_read_sz   <= req_sz;
                            end
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (lat_we) begin
                        // Memory commits at this edge; drop the strobe with it.
                        mem_write_we <= 1'b0;
                        resp_rdata   <= '0;
                        resp_valid   <= 1'b1;
                        state        <= ST_RESP;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        resp_rdata <= lat_sz ? mem_read_data : {8'h00, mem_read_data[7:0]};
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
